pdi_block_sequencer: RTL
========================

# pdi_block_sequencer

Sequences one PDI segment (AD or message) through the byte-padding multiplexer. It consumes bus words from the PDI stream and splits the segment into 128-bit blocks. For the final partial block it drives the mux controls (`cnt`, `seglen`, `pad`, `last`) and inserts padding-only words without consuming PDI. It sits between the PDI input FIFO and the Romulus state/tweakey datapath, which receives the mux output with the block-framing flags generated here.

## Interface

**Parameters**
- BUSW, 32 — PDI bus width in bits; the block supports only 32, so 4 words make one 128-bit block.
- CNTW, 2 — width of the word-in-block counter.
- LENW, 16 — width of the segment length, in bytes.

**Ports**
- clk  in  1  — the single clock.
- rst  in  1  — reset, asynchronous and active-high.
- seg_start  in  1  — start pulse for a segment; sampled only in IDLE.
- seg_len  in  LENW  — segment length in bytes; valid with seg_start.
- seg_busy  out  1  — high from seg_start acceptance until seg_done.
- seg_done  out  1  — one-cycle registered pulse after the segment's last word transfers.
- pdi_valid  in  1  — a PDI word is available.
- pdi_ready  out  1  — PDI word consumed; combinational.
- mux_cnt  out  CNTW  — word index within the current block; drives the mux `cnt` input.
- mux_seglen  out  4  — byte count of the partial block; drives the mux `seglen` input.
- mux_pad  out  1  — current block is partial; drives the mux `pad` input.
- mux_last  out  1  — length byte goes into this word; drives the mux `last` input.
- blk_valid  out  1  — a padded word is available downstream.
- blk_ready  in  1  — downstream accepts the word.
- blk_eob  out  1  — the current word is the last word of a 128-bit block.
- blk_eos  out  1  — the current word is the last word of the segment.
- blk_partial  out  1  — the current block is padded; same value as mux_pad.

## Operation

**States**
- IDLE
- LOAD — words carry PDI data.
- PAD — padding-only words; no PDI is consumed.

**Transfer rule**
- A transfer occurs when blk_valid and blk_ready are both high.
- In LOAD: blk_valid = pdi_valid and pdi_ready = blk_ready.
- In PAD: blk_valid = 1 and pdi_ready = 0.
- In IDLE: both are 0.

**Registers**
- rem (LENW): bytes of the segment still to consume.
- cnt (CNTW).
- seglen (4).
- partial (1).

**IDLE behaviour**
- When seg_start = 1:
  - rem ← seg_len and cnt ← 0.
  - partial ← (seg_len < 16) and seglen ← seg_len[3:0].
- If seg_len = 0, go to PAD. This emits one fully padded block with seglen = 0.
- Otherwise go to LOAD.
- seg_start is ignored while seg_busy is high.

**On each transfer in LOAD**
- rem ← rem − min(rem, 4) and cnt ← cnt + 1, wrapping 3→0.
- If the new rem = 0 and cnt = 3: the segment is finished. Go to IDLE and pulse seg_done. No extra padding block is added when the final block is full.
- If the new rem = 0 and cnt ≠ 3: go to PAD.
- If rem > 0 and cnt = 3 (block boundary):
  - partial ← (new rem < 16).
  - seglen ← new rem[3:0] if partial, else 0.

**On each transfer in PAD**
- cnt ← cnt + 1.
- When cnt = 3, go to IDLE and pulse seg_done.

**Combinational outputs**
- mux_cnt = cnt.
- mux_seglen = seglen when partial, else 0.
- mux_pad = partial.
- mux_last = partial & (cnt = 3).
- blk_eob = (cnt = 3) & blk_valid.
- blk_eos = blk_valid & one of:
  - PAD state and cnt = 3;
  - LOAD state, rem ≤ 4 and cnt = 3.

**Widths**
- rem is compared and decremented unsigned.
- seg_len up to 2^LENW − 1 is supported; no overflow is possible.

## Timing

- Reset values:
  - state IDLE; cnt 0; rem 0; seglen 0; partial 0; seg_done 0.
  - All combinational outputs evaluate to 0 in IDLE.
- First word: blk_valid can rise the cycle after seg_start. There are zero bubble cycles between words when pdi_valid and blk_ready are held high.
- Data words: pdi_ready → pdi_valid has no registered path (pass-through). Throughput is one word per cycle.
- Padding words: inserted back-to-back, one per cycle, subject to blk_ready.
- Backpressure: while blk_ready = 0, every output holds, pdi_ready = 0, and nothing is consumed.
- seg_done is asserted in the cycle after the final transfer. seg_busy falls in that same cycle, and a new seg_start is accepted in that cycle.
- Reset asserted mid-segment forces IDLE immediately. Any partially consumed PDI words are not replayed.

## Test plan

- **32-byte segment**, pdi_valid and blk_ready held high:
  - 8 LOAD transfers; pad = 0 throughout.
  - blk_eob on transfers 4 and 8; blk_eos on transfer 8.
  - seg_done one cycle later; no PAD words.
- **5-byte segment**:
  - 2 PDI words consumed, then 2 PAD words with pdi_ready = 0.
  - mux_seglen = 5 and mux_pad = 1 on all 4 words.
  - mux_last only on cnt = 3.
- **0-byte segment**:
  - 4 PAD words with mux_seglen = 0; mux_last on the 4th word.
  - pdi_ready never asserts.
- **20-byte segment**:
  - Block 1: 4 data words, pad = 0.
  - Block 2: pad = 1, seglen = 4, 1 data word then 3 PAD words; blk_eos on the 8th word.
- **Backpressure**: toggle blk_ready and pdi_valid randomly on a 37-byte segment. Required: same word sequence and flags as the stall-free run, and exactly 10 PDI words consumed.
- **Reset mid-segment**: assert rst during word 3 of a 48-byte segment. Required: all outputs return to reset values asynchronously, and a following 5-byte segment runs correctly.

Source files
------------

// File: rtl/pdi_block_sequencer.sv
// Splits one PDI segment into 128-bit blocks of four 32-bit words and drives the
// byte-padding mux controls, inserting padding-only words for the final partial block.
module pdi_block_sequencer #(
  parameter int BUSW = 32,
  parameter int CNTW = 2,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seg_start,
  input  logic [LENW-1:0] seg_len,
  output logic            seg_busy,
  output logic            seg_done,
  input  logic            pdi_valid,
  output logic            pdi_ready,
  output logic [CNTW-1:0] mux_cnt,
  output logic [3:0]      mux_seglen,
  output logic            mux_pad,
  output logic            mux_last,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic            blk_eob,
  output logic            blk_eos,
  output logic            blk_partial,
  output logic [1:0]      dbg_state
);

  localparam int WORD_BYTES = BUSW / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [3:0]      seglen_q, seglen_d;
  logic            partial_q, partial_d;
  logic            done_q, done_d;

  logic            xfer;
  logic            cnt_last;
  logic [LENW-1:0] rem_step;
  logic [LENW-1:0] rem_new;

  // Handshake: a word moves downstream when blk_valid && blk_ready. In LOAD the
  // PDI side is a pass-through (blk_valid = pdi_valid, pdi_ready = blk_ready); in
  // PAD words are self-generated (blk_valid = 1, pdi_ready = 0); IDLE drives neither.
  assign xfer     = blk_valid & blk_ready;
  assign cnt_last = (cnt_q == {CNTW{1'b1}});
  assign rem_step = (rem_q < LENW'(WORD_BYTES)) ? rem_q : LENW'(WORD_BYTES);
  assign rem_new  = rem_q - rem_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      cnt_q     <= '0;
      seglen_q  <= '0;
      partial_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      seglen_q  <= seglen_d;
      partial_q <= partial_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    seglen_d  = seglen_q;
    partial_d = partial_q;
    done_d    = 1'b0;
    blk_valid = 1'b0;
    pdi_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seg_start) begin
          rem_d     = seg_len;
          cnt_d     = '0;
          partial_d = (seg_len < LENW'(16));
          seglen_d  = seg_len[3:0];
          // An empty segment still emits one fully padded block.
          state_d   = (seg_len == '0) ? S_PAD : S_LOAD;
        end
      end
      S_LOAD: begin
        blk_valid = pdi_valid;
        pdi_ready = blk_ready;
        if (xfer) begin
          rem_d = rem_new;
          cnt_d = cnt_q + CNTW'(1);
          if (rem_new == '0) begin
            if (cnt_last) begin
              state_d   = S_IDLE;
              done_d    = 1'b1;
              partial_d = 1'b0;
              seglen_d  = '0;
            end else begin
              state_d = S_PAD;
            end
          end else if (cnt_last) begin
            partial_d = (rem_new < LENW'(16));
            seglen_d  = (rem_new < LENW'(16)) ? rem_new[3:0] : 4'd0;
          end
        end
      end
      S_PAD: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          cnt_d = cnt_q + CNTW'(1);
          if (cnt_last) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            partial_d = 1'b0;
            seglen_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign seg_busy    = (state_q != S_IDLE);
  assign seg_done    = done_q;
  assign mux_cnt     = cnt_q;
  assign mux_seglen  = partial_q ? seglen_q : 4'd0;
  assign mux_pad     = partial_q;
  assign mux_last    = partial_q & cnt_last;
  assign blk_partial = partial_q;
  assign blk_eob     = cnt_last & blk_valid;
  assign blk_eos     = blk_valid & cnt_last &
                       ((state_q == S_PAD) ||
                        ((state_q == S_LOAD) && (rem_q <= LENW'(WORD_BYTES))));
  assign dbg_state   = state_q;

endmodule
